// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory request/acknowledge bus between the fetch unit and imem.
//   imem_req   : fetch unit -> memory, request outstanding
//   imem_addr  : fetch unit -> memory, word address of the request
//   imem_ack   : memory -> fetch unit, imem_rdata valid this cycle
//   imem_rdata : memory -> fetch unit, instruction word
interface pc_fetch_unit_if;
    logic        imem_req;
    logic [29:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/pc_fetch_unit.sv
// PC register and instruction fetch for the multi-cycle MIPS core.
// Holds the architectural PC (word address), issues one imem fetch per accepted
// fetch_go, latches the returned word into IR and loads npc into PC on pc_wr.
//   clk, rst    : clock, synchronous active-high reset
//   fetch_go    : start a fetch of the word at pc
//   fetch_kill  : abort an in-flight fetch (blocks fetch_go while idle)
//   pc_wr, npc  : load npc into pc at this edge
//   pc          : current PC[31:2]
//   imem        : req/addr/ack/rdata bus to instruction memory
//   ir, ir_valid: instruction register, one-cycle pulse after IR update
//   fetch_busy  : request outstanding
//   fetch_err   : sticky timeout flag, cleared by rst or the next accepted fetch
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int unsigned TIMEOUT  = 16,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   fetch_go,
    input  logic                   fetch_kill,
    input  logic                   pc_wr,
    input  logic [29:0]            npc,
    output logic [29:0]            pc,
    pc_fetch_unit_if.master        imem,
    output logic [31:0]            ir,
    output logic                   ir_valid,
    output logic                   fetch_busy,
    output logic                   fetch_err
);

    localparam logic [CNT_W-1:0] CntLast = CNT_W'(TIMEOUT - 1);

    typedef enum logic [0:0] {StIdle, StReq} state_e;

    state_e             state_q, state_d;
    logic [29:0]        pc_q, pc_d;
    logic [29:0]        addr_q, addr_d;
    logic               req_q, req_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        ir_q, ir_d;
    logic               irv_q, irv_d;
    logic               err_q, err_d;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        req_d   = req_q;
        cnt_d   = cnt_q;
        ir_d    = ir_q;
        irv_d   = 1'b0;
        err_d   = err_q;
        // pc update is independent of the fetch; the fetch uses its own addr copy
        pc_d    = pc_wr ? npc : pc_q;

        unique case (state_q)
            StIdle: begin
                if (fetch_go && !fetch_kill) begin
                    addr_d  = pc_q;
                    req_d   = 1'b1;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    state_d = StReq;
                end
            end
            StReq: begin
                cnt_d = cnt_q + 1'b1;
                // Priority: kill, then ack, then timeout.
                if (fetch_kill) begin
                    req_d   = 1'b0;
                    state_d = StIdle;
                end else if (imem.imem_ack) begin
                    ir_d    = imem.imem_rdata;
                    irv_d   = 1'b1;
                    req_d   = 1'b0;
                    state_d = StIdle;
                end else if (cnt_q == CntLast) begin
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            pc_q    <= RESET_PC[31:2];
            addr_q  <= '0;
            req_q   <= 1'b0;
            cnt_q   <= '0;
            ir_q    <= '0;
            irv_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            req_q   <= req_d;
            cnt_q   <= cnt_d;
            ir_q    <= ir_d;
            irv_q   <= irv_d;
            err_q   <= err_d;
        end
    end

    assign pc             = pc_q;
    assign imem.imem_req  = req_q;
    assign imem.imem_addr = addr_q;
    assign ir             = ir_q;
    assign ir_valid       = irv_q;
    assign fetch_busy     = (state_q == StReq);
    assign fetch_err      = err_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;

    localparam int unsigned Timeout = 4;
    localparam logic [29:0] RstWord = 30'h0000_0C00;

    logic        clk = 1'b0;
    logic        rst, fetch_go, fetch_kill, pc_wr;
    logic [29:0] npc, pc;
    logic [31:0] ir;
    logic        ir_valid, fetch_busy, fetch_err;

    int errors = 0;
    int checks = 0;

    pc_fetch_unit_if bus ();

    pc_fetch_unit #(
        .RESET_PC (32'h0000_3000),
        .TIMEOUT  (Timeout),
        .CNT_W    (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .fetch_go   (fetch_go),
        .fetch_kill (fetch_kill),
        .pc_wr      (pc_wr),
        .npc        (npc),
        .pc         (pc),
        .imem       (bus.master),
        .ir         (ir),
        .ir_valid   (ir_valid),
        .fetch_busy (fetch_busy),
        .fetch_err  (fetch_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, go, kill, pcw;
        logic [29:0] npc;
        logic        ack;
        logic [31:0] rdata;
        logic [29:0] e_pc;
        logic        e_req;
        logic [29:0] e_addr;
        logic [31:0] e_ir;
        logic        e_irv, e_err;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(logic r, logic g, logic k, logic w, logic [29:0] n, logic a,
                                logic [31:0] d, logic [29:0] epc, logic ereq,
                                logic [29:0] eaddr, logic [31:0] eir, logic eirv, logic eerr);
        vec_t v;
        v.rst = r; v.go = g; v.kill = k; v.pcw = w; v.npc = n; v.ack = a; v.rdata = d;
        v.e_pc = epc; v.e_req = ereq; v.e_addr = eaddr; v.e_ir = eir;
        v.e_irv = eirv; v.e_err = eerr;
        vecs.push_back(v);
    endfunction

    task automatic chk(string name, int idx, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic drive(logic r, logic g, logic k, logic w, logic [29:0] n, logic a,
                         logic [31:0] d);
        rst = r; fetch_go = g; fetch_kill = k; pc_wr = w; npc = n;
        bus.imem_ack = a; bus.imem_rdata = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(int idx, logic [29:0] epc, logic ereq, logic [29:0] eaddr,
                             logic [31:0] eir, logic eirv, logic eerr);
        chk("pc", idx, {2'b0, pc}, {2'b0, epc});
        chk("imem_req", idx, {31'b0, bus.imem_req}, {31'b0, ereq});
        chk("fetch_busy", idx, {31'b0, fetch_busy}, {31'b0, ereq});
        chk("imem_addr", idx, {2'b0, bus.imem_addr}, {2'b0, eaddr});
        chk("ir", idx, ir, eir);
        chk("ir_valid", idx, {31'b0, ir_valid}, {31'b0, eirv});
        chk("fetch_err", idx, {31'b0, fetch_err}, {31'b0, eerr});
    endtask

    // Transaction-level reference: one outstanding fetch with an age in cycles.
    logic [29:0] m_pc, m_addr;
    logic [31:0] m_ir;
    logic        m_irv, m_err, m_busy;
    int          m_age;

    function automatic void model_step(logic r, logic g, logic k, logic w, logic [29:0] n,
                                       logic a, logic [31:0] d);
        if (r) begin
            m_pc = RstWord; m_addr = '0; m_ir = '0; m_irv = 0; m_err = 0;
            m_busy = 0; m_age = 0;
            return;
        end
        m_irv = 0;
        if (m_busy) begin
            m_age = m_age + 1;  // number of request cycles seen, including this one
            if (k) m_busy = 0;
            else if (a) begin
                m_ir = d; m_irv = 1; m_busy = 0;
            end else if (m_age >= Timeout) begin
                m_err = 1; m_busy = 0;
            end
        end else if (g && !k) begin
            m_busy = 1; m_addr = m_pc; m_age = 0; m_err = 0;
        end
        if (w) m_pc = n;
    endfunction

    initial begin
        logic [29:0] c00, c01;
        c00 = RstWord;
        c01 = 30'h0000_0C01;
        drive(1, 0, 0, 0, '0, 0, '0);

        //   rst go kl pw npc  ack rdata          pc   req addr ir              irv err
        // reset
        add(1, 0, 0, 0, '0,  0, '0,            c00, 0, '0,  '0,            0, 0);
        add(1, 0, 0, 0, '0,  0, '0,            c00, 0, '0,  '0,            0, 0);
        add(0, 0, 0, 0, '0,  0, '0,            c00, 0, '0,  '0,            0, 0);
        // single-cycle ack
        add(0, 1, 0, 0, '0,  0, '0,            c00, 1, c00, '0,            0, 0);
        add(0, 0, 0, 0, '0,  1, 32'h2408_0005, c00, 0, c00, 32'h2408_0005, 1, 0);
        add(0, 0, 0, 0, '0,  0, '0,            c00, 0, c00, 32'h2408_0005, 0, 0);
        // pc_wr during a three-cycle wait
        add(0, 1, 0, 0, '0,  0, '0,            c00, 1, c00, 32'h2408_0005, 0, 0);
        add(0, 0, 0, 1, c01, 0, '0,            c01, 1, c00, 32'h2408_0005, 0, 0);
        add(0, 0, 0, 0, '0,  0, '0,            c01, 1, c00, 32'h2408_0005, 0, 0);
        add(0, 0, 0, 0, '0,  1, 32'h1111_2222, c01, 0, c00, 32'h1111_2222, 1, 0);
        add(0, 0, 0, 0, '0,  0, '0,            c01, 0, c00, 32'h1111_2222, 0, 0);
        // timeout after four request cycles, then err cleared by next fetch
        add(0, 1, 0, 0, '0,  0, '0,            c01, 1, c01, 32'h1111_2222, 0, 0);
        add(0, 0, 0, 0, '0,  0, '0,            c01, 1, c01, 32'h1111_2222, 0, 0);
        add(0, 0, 0, 0, '0,  0, '0,            c01, 1, c01, 32'h1111_2222, 0, 0);
        add(0, 0, 0, 0, '0,  0, '0,            c01, 1, c01, 32'h1111_2222, 0, 0);
        add(0, 0, 0, 0, '0,  0, '0,            c01, 0, c01, 32'h1111_2222, 0, 1);
        add(0, 0, 0, 0, '0,  1, 32'h9999_9999, c01, 0, c01, 32'h1111_2222, 0, 1);
        add(0, 1, 0, 0, '0,  0, '0,            c01, 1, c01, 32'h1111_2222, 0, 0);
        add(0, 0, 0, 0, '0,  1, 32'h3333_4444, c01, 0, c01, 32'h3333_4444, 1, 0);
        // kill beats a same-cycle ack
        add(0, 1, 0, 0, '0,  0, '0,            c01, 1, c01, 32'h3333_4444, 0, 0);
        add(0, 0, 1, 0, '0,  1, 32'hDEAD_BEEF, c01, 0, c01, 32'h3333_4444, 0, 0);
        add(0, 1, 0, 0, '0,  0, '0,            c01, 1, c01, 32'h3333_4444, 0, 0);
        add(0, 0, 0, 0, '0,  1, 32'h5555_6666, c01, 0, c01, 32'h5555_6666, 1, 0);
        // kill in idle blocks go
        add(0, 1, 1, 0, '0,  0, '0,            c01, 0, c01, 32'h5555_6666, 0, 0);
        // reset mid-fetch, late ack ignored
        add(0, 1, 0, 0, '0,  0, '0,            c01, 1, c01, 32'h5555_6666, 0, 0);
        add(1, 0, 0, 0, '0,  0, '0,            c00, 0, '0,  '0,            0, 0);
        add(0, 0, 0, 0, '0,  1, 32'h0000_ABCD, c00, 0, '0,  '0,            0, 0);
        // ack coinciding with timeout expiry wins
        add(0, 1, 0, 0, '0,  0, '0,            c00, 1, c00, '0,            0, 0);
        add(0, 0, 0, 0, '0,  0, '0,            c00, 1, c00, '0,            0, 0);
        add(0, 0, 0, 0, '0,  0, '0,            c00, 1, c00, '0,            0, 0);
        add(0, 0, 0, 0, '0,  0, '0,            c00, 1, c00, '0,            0, 0);
        add(0, 0, 0, 0, '0,  1, 32'h7777_8888, c00, 0, c00, 32'h7777_8888, 1, 0);
        // new fetch accepted while ir_valid is high
        add(0, 1, 0, 0, '0,  0, '0,            c00, 1, c00, 32'h7777_8888, 0, 0);
        add(0, 0, 1, 0, '0,  0, '0,            c00, 0, c00, 32'h7777_8888, 0, 0);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].go, vecs[i].kill, vecs[i].pcw, vecs[i].npc,
                  vecs[i].ack, vecs[i].rdata);
            tick();
            check_all(i, vecs[i].e_pc, vecs[i].e_req, vecs[i].e_addr, vecs[i].e_ir,
                      vecs[i].e_irv, vecs[i].e_err);
        end

        // Randomised run against the reference model, starting from reset.
        for (int i = 0; i < 2000; i++) begin
            logic r, g, k, w, a;
            logic [29:0] n;
            logic [31:0] d;
            r = (i == 0) || ($urandom_range(0, 99) < 2);
            g = ($urandom_range(0, 1) == 1);
            k = ($urandom_range(0, 9) == 0);
            w = ($urandom_range(0, 4) == 0);
            a = ($urandom_range(0, 9) < 3);
            n = 30'($urandom);
            d = $urandom;
            drive(r, g, k, w, n, a, d);
            model_step(r, g, k, w, n, a, d);
            tick();
            check_all(1000 + i, m_pc, m_busy, m_addr, m_ir, m_irv, m_err);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Owns the architectural PC register of the multi-cycle MIPS core and performs instruction fetch from instruction memory over a req/ack handshake.
- Latches the fetched word into IR and exposes PC[31:2] to the next-PC generator.
- Loads the next-PC generator's result back into PC when the controller asserts pc_wr.
- Acts as the consumer/closing end of the next-PC path.

Parameters:
- RESET_PC, 32'h0000_3000, byte address loaded on reset; only bits [31:2] are used.
- TIMEOUT, 16, max cycles in REQ without imem_ack before the fetch aborts with error (1..65535).
- CNT_W, 16, width of the timeout counter; must hold TIMEOUT.

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- fetch_go  in  1  controller request to fetch the word at the current PC.
- fetch_kill  in  1  abort any in-flight fetch.
- pc_wr  in  1  load npc into PC this edge.
- npc  in  30  next word address from the next-PC generator.
- pc  out  30  current PC[31:2]; feeds the next-PC generator.
- imem_req  out  1  instruction memory request.
- imem_addr  out  30  word address of the in-flight fetch.
- imem_ack  in  1  memory reports imem_rdata valid.
- imem_rdata  in  32  instruction word.
- ir  out  32  instruction register.
- ir_valid  out  1  one-cycle pulse after IR is updated.
- fetch_busy  out  1  high while in REQ.
- fetch_err  out  1  sticky timeout flag.

Behaviour:
- Reset (rst high at an edge, any state, including mid-fetch):
  - pc = RESET_PC[31:2] (30'h0000_0C00 at the default).
  - ir = 0; imem_req = 0; imem_addr = 0; ir_valid = 0; fetch_err = 0; timeout counter = 0; state = IDLE.
  - rst overrides every other input.
- States are IDLE and REQ. All outputs are registered.
- IDLE:
  - fetch_go=1 and fetch_kill=0: imem_addr <= pc (value before any same-edge pc_wr), imem_req <= 1, counter <= 0, fetch_err <= 0, go to REQ.
  - fetch_go=0: stay in IDLE.
- REQ:
  - imem_req and imem_addr are held constant.
  - fetch_go is ignored.
  - counter increments each cycle.
- Completion: in REQ, imem_ack=1 while imem_req=1:
  - ir <= imem_rdata; imem_req <= 0; ir_valid <= 1 for exactly the next cycle; go to IDLE.
  - Minimum latency: fetch_go sampled at edge N, req visible in cycle N+1; ack in cycle N+1 gives ir/ir_valid at edge N+2.
  - A new fetch_go is accepted in the same cycle ir_valid is high (state is IDLE).
- Timeout: counter reaches TIMEOUT-1 with no ack:
  - imem_req <= 0; fetch_err <= 1; ir unchanged; no ir_valid; go to IDLE.
  - If ack and expiry coincide, ack wins and fetch_err stays 0.
- fetch_kill in REQ: imem_req <= 0, go to IDLE, ir unchanged, no ir_valid, fetch_err unchanged. An ack in the same cycle is discarded (kill wins).
- fetch_kill in IDLE has no effect, and fetch_go is not accepted in that cycle.
- imem_ack while imem_req=0 is ignored.
- pc_wr is honoured in any state: pc <= npc at the edge. An in-flight fetch is unaffected because imem_addr is separately latched.
- PC is a 30-bit word address:
  - Wraps naturally (30'h3FFF_FFFF + 1 = 0, computed upstream).
  - No alignment faults are possible.
- fetch_err clears only on rst or on the next accepted fetch_go.

Test Plan:
1. Apply rst 2 cycles, release -> pc=30'h0000_0C00, ir=0, imem_req=0, fetch_err=0, ir_valid=0.
2. fetch_go 1 cycle; memory acks in the first req cycle with rdata 32'h2408_0005 -> imem_addr=30'h0C00 during req; ir=32'h2408_0005 and ir_valid high for exactly 1 cycle two edges after fetch_go; fetch_busy high for 1 cycle.
3. fetch_go, then pc_wr with npc=30'h0C01 during a 3-cycle ack wait -> imem_addr stays 30'h0C00; pc=30'h0C01 right after the pc_wr edge; ir captures the acked data.
4. TIMEOUT=4, fetch_go, no ack -> imem_req high 4 cycles then low; fetch_err=1; ir unchanged. Next fetch_go -> fetch_err=0.
5. fetch_go, fetch_kill asserted in the same cycle as imem_ack (rdata 32'hDEAD_BEEF) -> no ir_valid; ir keeps its old value; state IDLE; subsequent fetch works.
6. rst asserted during REQ, then ack arrives -> imem_req=0 after the reset edge; ack ignored; pc=30'h0C00; ir=0.
